// File: rtl/multi_vc_initial_logic.sv
// multi_vc_initial_logic: input FIFO routed by word upper bits into NUM_VC per-VC FIFOs with flags, pause and sticky errors
module multi_vc_initial_logic #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2,
    parameter int NUM_VC     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_enable,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic [NUM_VC-1:0]            pop_vc,
    input  logic [ADDR_WIDTH:0]          afull_thresh,
    input  logic [ADDR_WIDTH:0]          aempty_thresh,
    output logic [NUM_VC*DATA_WIDTH-1:0] data_out_vc,
    output logic [NUM_VC-1:0]            valid_vc,
    output logic [NUM_VC-1:0]            full_vc,
    output logic [NUM_VC-1:0]            empty_vc,
    output logic [NUM_VC-1:0]            almost_full_vc,
    output logic [NUM_VC-1:0]            almost_empty_vc,
    output logic [NUM_VC-1:0]            pause_vc,
    output logic [NUM_VC-1:0]            error_vc,
    output logic                         full_in,
    output logic                         empty_in,
    output logic                         pause_in,
    output logic                         error_in
);
    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int VC_BITS = $clog2(NUM_VC);
    logic [DATA_WIDTH-1:0] mem_in [DEPTH];
    logic [DATA_WIDTH-1:0] mem_vc [NUM_VC][DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_in, rd_ptr_in;
    logic [ADDR_WIDTH-1:0] wr_ptr_vc [NUM_VC];
    logic [ADDR_WIDTH-1:0] rd_ptr_vc [NUM_VC];
    logic [ADDR_WIDTH:0]   cnt_in;
    logic [ADDR_WIDTH:0]   cnt_vc [NUM_VC];
    logic [DATA_WIDTH-1:0] head;
    logic [VC_BITS:0]      sel;
    logic                  bad_sel, route_pop, wr_ok;
    logic [NUM_VC-1:0]     push_vc, pop_ok;

    always_comb begin
        head      = mem_in[rd_ptr_in];
        sel       = {1'b0, head[DATA_WIDTH-1 -: VC_BITS]};
        bad_sel   = sel >= (VC_BITS+1)'(NUM_VC);
        full_in   = cnt_in == (ADDR_WIDTH+1)'(DEPTH);
        empty_in  = cnt_in == '0;
        pause_in  = afull_thresh != '0 && cnt_in >= afull_thresh;
        wr_ok     = wr_enable && !full_in;
        full_vc         = '0;
        empty_vc        = '0;
        almost_full_vc  = '0;
        almost_empty_vc = '0;
        push_vc         = '0;
        pop_ok          = '0;
        for (int k = 0; k < NUM_VC; k++) begin
            full_vc[k]         = cnt_vc[k] == (ADDR_WIDTH+1)'(DEPTH);
            empty_vc[k]        = cnt_vc[k] == '0;
            almost_full_vc[k]  = afull_thresh != '0 && cnt_vc[k] >= afull_thresh;
            almost_empty_vc[k] = cnt_vc[k] <= aempty_thresh;
            push_vc[k]         = !empty_in && sel == (VC_BITS+1)'(k) && !full_vc[k];
            pop_ok[k]          = pop_vc[k] && !empty_vc[k];
        end
        // invalid selects are drained so they cannot block the input FIFO
        route_pop = !empty_in && (bad_sel || |push_vc);
        pause_vc  = almost_full_vc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_in   <= '0;
            rd_ptr_in   <= '0;
            cnt_in      <= '0;
            data_out_vc <= '0;
            valid_vc    <= '0;
            error_vc    <= '0;
            error_in    <= 1'b0;
            for (int k = 0; k < NUM_VC; k++) begin
                wr_ptr_vc[k] <= '0;
                rd_ptr_vc[k] <= '0;
                cnt_vc[k]    <= '0;
            end
        end else begin
            if (wr_ok) begin
                mem_in[wr_ptr_in] <= data_in;
                wr_ptr_in         <= wr_ptr_in + ADDR_WIDTH'(1);
            end
            if (route_pop) rd_ptr_in <= rd_ptr_in + ADDR_WIDTH'(1);
            cnt_in   <= cnt_in + (ADDR_WIDTH+1)'(wr_ok) - (ADDR_WIDTH+1)'(route_pop);
            error_in <= error_in | (wr_enable && full_in) | (!empty_in && bad_sel);
            for (int k = 0; k < NUM_VC; k++) begin
                if (push_vc[k]) begin
                    mem_vc[k][wr_ptr_vc[k]] <= head;
                    wr_ptr_vc[k]            <= wr_ptr_vc[k] + ADDR_WIDTH'(1);
                end
                if (pop_ok[k]) begin
                    data_out_vc[k*DATA_WIDTH +: DATA_WIDTH] <= mem_vc[k][rd_ptr_vc[k]];
                    rd_ptr_vc[k]                            <= rd_ptr_vc[k] + ADDR_WIDTH'(1);
                end
                valid_vc[k] <= pop_ok[k];
                error_vc[k] <= error_vc[k] | (pop_vc[k] && empty_vc[k]);
                cnt_vc[k]   <= cnt_vc[k] + (ADDR_WIDTH+1)'(push_vc[k]) - (ADDR_WIDTH+1)'(pop_ok[k]);
            end
        end
    end
endmodule

// File: tb/tb_multi_vc_initial_logic.sv
// tb_multi_vc_initial_logic: random and directed traffic on 2-VC and 3-VC instances against a queue-based model
module tb_multi_vc_initial_logic;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_enable = 1'b0;
    logic [5:0] data_in = '0;
    logic [2:0] pop_vc = '0;
    logic [2:0] afull_thresh = '0;
    logic [2:0] aempty_thresh = '0;

    logic [11:0] dout_a;
    logic [1:0]  valid_a, full_a, empty_a, af_a, ae_a, pause_a, err_a;
    logic        full_in_a, empty_in_a, pause_in_a, err_in_a;
    logic [17:0] dout_b;
    logic [2:0]  valid_b, full_b, empty_b, af_b, ae_b, pause_b, err_b;
    logic        full_in_b, empty_in_b, pause_in_b, err_in_b;

    multi_vc_initial_logic #(.DATA_WIDTH(6), .ADDR_WIDTH(2), .NUM_VC(2)) dut_a (
        .clk(clk), .reset(reset), .wr_enable(wr_enable), .data_in(data_in), .pop_vc(pop_vc[1:0]),
        .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh), .data_out_vc(dout_a),
        .valid_vc(valid_a), .full_vc(full_a), .empty_vc(empty_a), .almost_full_vc(af_a),
        .almost_empty_vc(ae_a), .pause_vc(pause_a), .error_vc(err_a), .full_in(full_in_a),
        .empty_in(empty_in_a), .pause_in(pause_in_a), .error_in(err_in_a));

    multi_vc_initial_logic #(.DATA_WIDTH(6), .ADDR_WIDTH(2), .NUM_VC(3)) dut_b (
        .clk(clk), .reset(reset), .wr_enable(wr_enable), .data_in(data_in), .pop_vc(pop_vc),
        .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh), .data_out_vc(dout_b),
        .valid_vc(valid_b), .full_vc(full_b), .empty_vc(empty_b), .almost_full_vc(af_b),
        .almost_empty_vc(ae_b), .pause_vc(pause_b), .error_vc(err_b), .full_in(full_in_b),
        .empty_in(empty_in_b), .pause_in(pause_in_b), .error_in(err_in_b));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [5:0] qin [2][$];
    logic [5:0] qvc [2][3][$];
    logic [5:0] dout_m [2][3];
    logic [2:0] valid_m [2];
    logic [2:0] err_vc_m [2];
    logic       err_in_m [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    // one clock edge of the block's behaviour, evaluated on pre-edge occupancy
    task automatic step(input int i, input int nv);
        int sz [3];
        int sel;
        bit fin;
        logic [5:0] h;
        if (reset) begin
            qin[i].delete();
            for (int k = 0; k < 3; k++) begin
                qvc[i][k].delete();
                dout_m[i][k] = '0;
            end
            valid_m[i] = '0; err_vc_m[i] = '0; err_in_m[i] = 1'b0;
            return;
        end
        fin = qin[i].size() == 4;
        for (int k = 0; k < 3; k++) sz[k] = qvc[i][k].size();
        valid_m[i] = '0;
        for (int k = 0; k < nv; k++)
            if (pop_vc[k]) begin
                if (sz[k] > 0) begin
                    dout_m[i][k] = qvc[i][k].pop_front();
                    valid_m[i][k] = 1'b1;
                end else err_vc_m[i][k] = 1'b1;
            end
        if (qin[i].size() > 0) begin
            h = qin[i][0];
            sel = (nv == 2) ? int'(h) / 32 : int'(h) / 16;
            if (sel >= nv) begin
                void'(qin[i].pop_front());
                err_in_m[i] = 1'b1;
            end else if (sz[sel] < 4) begin
                void'(qin[i].pop_front());
                qvc[i][sel].push_back(h);
            end
        end
        if (wr_enable) begin
            if (fin) err_in_m[i] = 1'b1;
            else qin[i].push_back(data_in);
        end
    endtask

    function automatic logic [2:0] flags(input int i, input int typ);
        logic [2:0] f = '0;
        int s;
        for (int k = 0; k < 3; k++) begin
            s = qvc[i][k].size();
            f[k] = typ == 0 ? s == 0 : typ == 1 ? s == 4 :
                   typ == 2 ? (afull_thresh != 0 && s >= int'(afull_thresh)) : s <= int'(aempty_thresh);
        end
        return f;
    endfunction

    function automatic logic [2:0] in_flags(input int i);
        int s = qin[i].size();
        return {s == 0, s == 4, afull_thresh != 0 && s >= int'(afull_thresh)};
    endfunction

    task automatic check_all();
        logic [2:0] e;
        chk("a.data_out", 32'(dout_a), 32'({dout_m[0][1], dout_m[0][0]}));
        chk("a.valid", 32'(valid_a), 32'(valid_m[0][1:0]));
        chk("a.error_vc", 32'(err_a), 32'(err_vc_m[0][1:0]));
        chk("a.error_in", 32'(err_in_a), 32'(err_in_m[0]));
        e = flags(0, 0); chk("a.empty_vc", 32'(empty_a), 32'(e[1:0]));
        e = flags(0, 1); chk("a.full_vc", 32'(full_a), 32'(e[1:0]));
        e = flags(0, 2); chk("a.afull_vc", 32'(af_a), 32'(e[1:0]));
        chk("a.pause_vc", 32'(pause_a), 32'(e[1:0]));
        e = flags(0, 3); chk("a.aempty_vc", 32'(ae_a), 32'(e[1:0]));
        chk("a.in_flags", 32'({empty_in_a, full_in_a, pause_in_a}), 32'(in_flags(0)));
        chk("b.data_out", 32'(dout_b), 32'({dout_m[1][2], dout_m[1][1], dout_m[1][0]}));
        chk("b.valid", 32'(valid_b), 32'(valid_m[1]));
        chk("b.error_vc", 32'(err_b), 32'(err_vc_m[1]));
        chk("b.error_in", 32'(err_in_b), 32'(err_in_m[1]));
        chk("b.empty_vc", 32'(empty_b), 32'(flags(1, 0)));
        chk("b.full_vc", 32'(full_b), 32'(flags(1, 1)));
        chk("b.afull_vc", 32'(af_b), 32'(flags(1, 2)));
        chk("b.pause_vc", 32'(pause_b), 32'(flags(1, 2)));
        chk("b.aempty_vc", 32'(ae_b), 32'(flags(1, 3)));
        chk("b.in_flags", 32'({empty_in_b, full_in_b, pause_in_b}), 32'(in_flags(1)));
    endtask

    task automatic cyc(input logic w, input logic [5:0] d, input logic [2:0] p);
        wr_enable = w; data_in = d; pop_vc = p;
        @(posedge clk);
        step(0, 2);
        step(1, 3);
        @(negedge clk);
        check_all();
        wr_enable = 1'b0; pop_vc = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("reset.empty_vc", 32'(empty_a), 32'h3);
        chk("reset.data_out", 32'(dout_a), 32'h0);
        cyc(1, 6'h05, 0);
        cyc(1, 6'h25, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 3'b011);
        chk("basic.valid", 32'(valid_a), 32'h3);
        chk("basic.data_out", 32'(dout_a), 32'({6'h25, 6'h05}));
        do_reset();
        afull_thresh = 3'd3;
        for (int j = 0; j < 4; j++) cyc(1, 6'(j), 0);
        cyc(1, 6'h01, 0);
        cyc(1, 6'h21, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("hol.full_vc0", 32'(full_a[0]), 32'h1);
        chk("hol.pause_vc0", 32'(pause_a[0]), 32'h1);
        chk("hol.empty_vc1", 32'(empty_a[1]), 32'h1);
        cyc(0, 0, 3'b001);
        cyc(0, 0, 0);
        chk("hol.vc1_still_empty", 32'(empty_a[1]), 32'h1);
        cyc(0, 0, 0);
        chk("hol.vc1_filled", 32'(empty_a[1]), 32'h0);
        do_reset();
        for (int j = 0; j < 8; j++) cyc(1, 6'(j), 0);
        chk("ovf.full_in", 32'(full_in_a), 32'h1);
        chk("ovf.no_error_yet", 32'(err_in_a), 32'h0);
        cyc(1, 6'h0f, 0);
        chk("ovf.error_in", 32'(err_in_a), 32'h1);
        cyc(0, 0, 3'b010);
        chk("popempty.error_vc", 32'(err_a), 32'h2);
        chk("popempty.valid", 32'(valid_a), 32'h0);
        do_reset();
        cyc(1, 6'h30, 0);
        cyc(0, 0, 0);
        chk("badsel.error_in", 32'(err_in_b), 32'h1);
        chk("badsel.empty_in", 32'(empty_in_b), 32'h1);
        chk("badsel.empty_vc", 32'(empty_b), 32'h7);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) afull_thresh = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 49) == 0) aempty_thresh = 3'($urandom_range(0, 4));
            reset = $urandom_range(0, 299) == 0;
            cyc($urandom_range(0, 9) < 6, 6'($urandom), 3'($urandom) & 3'($urandom | ($urandom_range(0, 1) ? 7 : 0)));
            reset = 1'b0;
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
